// File: rtl/result_display.sv
// Result display: counts CPU cycles until the harness halts, latches the answer byte,
// and scans it onto an 8-digit active-low seven-segment display (an/seg registered, 1-cycle latency).
// No backpressure: free-running scan; optional cycle counter under RESULT_DISPLAY_CYCLE_COUNT_EN.
module result_display #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       terminal,
   input  logic [7:0] answer,
   output logic       done,
   output logic [7:0] an,
   output logic [7:0] seg
);

   // Last prescaler value before it wraps; SCAN_DIV may be as large as 65536.
   localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

   // Dash shown on the result digits while the CPU is still running.
   localparam logic [7:0] SEG_DASH  = 8'hBF;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  res_q, res_d;
   logic [15:0] psc_q, psc_d;
   logic        tick;
   logic [2:0]  dig_q, dig_d;
   logic [7:0]  an_q, an_d;
   logic [7:0]  seg_q, seg_d;

   // Hex nibble to active-low segment pattern {dp,g,f,e,d,c,b,a}, dp off.
   function automatic logic [7:0] hex7(input logic [3:0] nib);
      logic [7:0] s;
      case (nib)
         4'h0:    s = 8'hC0;
         4'h1:    s = 8'hF9;
         4'h2:    s = 8'hA4;
         4'h3:    s = 8'hB0;
         4'h4:    s = 8'h99;
         4'h5:    s = 8'h92;
         4'h6:    s = 8'h82;
         4'h7:    s = 8'hF8;
         4'h8:    s = 8'h80;
         4'h9:    s = 8'h90;
         4'hA:    s = 8'h88;
         4'hB:    s = 8'h83;
         4'hC:    s = 8'hC6;
         4'hD:    s = 8'hA1;
         4'hE:    s = 8'h86;
         default: s = 8'h8E;
      endcase
      return s;
   endfunction

   // Next state: leave RUN on the first sampled terminal and capture the answer on that edge only.
   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      if (state_q == ST_RUN && terminal) begin
         state_d = ST_DONE;
         res_d   = answer;
      end
   end

   // State and latched result registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_RUN;
         res_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
      end
   end

   assign done = (state_q == ST_DONE);

`ifdef RESULT_DISPLAY_CYCLE_COUNT_EN
   logic [23:0] cyc_q, cyc_d;
   logic [3:0]  cyc_nib;

   // Count RUN edges that have not yet seen terminal; saturate instead of wrapping.
   always_comb begin
      cyc_d = cyc_q;
      if (state_q == ST_RUN && !terminal && cyc_q != 24'hFFFFFF) begin
         cyc_d = cyc_q + 24'd1;
      end
   end

   // Cycle counter register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cyc_q <= 24'h000000;
      end else begin
         cyc_q <= cyc_d;
      end
   end

   // Select the counter nibble for digits 7:2, digit 7 carrying the MSB nibble.
   always_comb begin
      cyc_nib = 4'h0;
      case (dig_q)
         3'd2:    cyc_nib = cyc_q[3:0];
         3'd3:    cyc_nib = cyc_q[7:4];
         3'd4:    cyc_nib = cyc_q[11:8];
         3'd5:    cyc_nib = cyc_q[15:12];
         3'd6:    cyc_nib = cyc_q[19:16];
         3'd7:    cyc_nib = cyc_q[23:20];
         default: cyc_nib = 4'h0;
      endcase
   end
`endif

   // Scan prescaler and digit index; the index steps once per prescaler wrap.
   always_comb begin
      tick  = (psc_q == SCAN_LAST);
      psc_d = tick ? 16'h0000 : psc_q + 16'h0001;
      dig_d = tick ? dig_q + 3'd1 : dig_q;
   end

   // Prescaler and digit index registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         psc_q <= 16'h0000;
         dig_q <= 3'd0;
      end else begin
         psc_q <= psc_d;
         dig_q <= dig_d;
      end
   end

   // Digit content for the currently selected index; unselected/blank digits stay dark.
   always_comb begin
      an_d  = 8'hFF;
      seg_d = SEG_BLANK;
      case (dig_q)
         3'd0: begin
            an_d  = 8'hFE;
            seg_d = (state_q == ST_DONE) ? hex7(res_q[3:0]) : SEG_DASH;
         end
         3'd1: begin
            an_d  = 8'hFD;
            seg_d = (state_q == ST_DONE) ? hex7(res_q[7:4]) : SEG_DASH;
         end
         default: begin
`ifdef RESULT_DISPLAY_CYCLE_COUNT_EN
            an_d  = ~(8'h01 << dig_q);
            seg_d = hex7(cyc_nib);
`else
            an_d  = 8'hFF;
            seg_d = SEG_BLANK;
`endif
         end
      endcase
   end

   // Registered display drive so an/seg switch together, glitch-free.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         an_q  <= 8'hFF;
         seg_q <= SEG_BLANK;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;

endmodule
